// File: rtl/tt_um_sujith_alu4.sv
// ============================================================================
// Module      : tt_um_sujith_alu4
// Description : 4-bit ALU with 16 opcodes and a registered {V,N,Z,C,R} output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_sujith_alu4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] c_op_add = 4'd0;
  localparam logic [3:0] c_op_adc = 4'd1;
  localparam logic [3:0] c_op_sub = 4'd2;
  localparam logic [3:0] c_op_sbc = 4'd3;
  localparam logic [3:0] c_op_and = 4'd4;
  localparam logic [3:0] c_op_or  = 4'd5;
  localparam logic [3:0] c_op_xor = 4'd6;
  localparam logic [3:0] c_op_not = 4'd7;
  localparam logic [3:0] c_op_shl = 4'd8;
  localparam logic [3:0] c_op_shr = 4'd9;
  localparam logic [3:0] c_op_asr = 4'd10;
  localparam logic [3:0] c_op_rol = 4'd11;
  localparam logic [3:0] c_op_inc = 4'd12;
  localparam logic [3:0] c_op_dec = 4'd13;
  localparam logic [3:0] c_op_mul = 4'd14;
  localparam logic [3:0] c_op_cmp = 4'd15;

  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [3:0] w_nb;
  logic [3:0] w_op;
  logic       w_cin;
  logic [4:0] w_sum;
  logic [7:0] w_prod;
  logic [3:0] w_res;
  logic [3:0] w_flag_src;
  logic       w_c;
  logic       w_v;
  logic       w_z;
  logic       w_n;
  logic [7:0] r_out;
  logic       w_unused_ok;

  assign w_a   = ui_in[3:0];
  assign w_b   = ui_in[7:4];
  assign w_nb  = ~ui_in[7:4];
  assign w_op  = uio_in[3:0];
  assign w_cin = uio_in[4];
  assign w_prod = {4'b0000, w_a} * {4'b0000, w_b};

  assign w_unused_ok = ^uio_in[7:5];

  always_comb begin
    w_sum = 5'd0;
    w_res = 4'd0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      c_op_add: begin
        w_sum = {1'b0, w_a} + {1'b0, w_b};
        w_res = w_sum[3:0];
        w_c   = w_sum[4];
        w_v   = (w_a[3] == w_b[3]) && (w_sum[3] != w_a[3]);
      end
      c_op_adc: begin
        w_sum = {1'b0, w_a} + {1'b0, w_b} + {4'b0000, w_cin};
        w_res = w_sum[3:0];
        w_c   = w_sum[4];
        w_v   = (w_a[3] == w_b[3]) && (w_sum[3] != w_a[3]);
      end
      c_op_sub, c_op_cmp: begin
        w_sum = {1'b0, w_a} + {1'b0, w_nb} + 5'd1;
        w_res = (w_op == c_op_cmp) ? w_a : w_sum[3:0];
        w_c   = w_sum[4];
        w_v   = (w_a[3] != w_b[3]) && (w_sum[3] != w_a[3]);
      end
      c_op_sbc: begin
        w_sum = {1'b0, w_a} + {1'b0, w_nb} + {4'b0000, w_cin};
        w_res = w_sum[3:0];
        w_c   = w_sum[4];
        w_v   = (w_a[3] != w_b[3]) && (w_sum[3] != w_a[3]);
      end
      c_op_and: w_res = w_a & w_b;
      c_op_or:  w_res = w_a | w_b;
      c_op_xor: w_res = w_a ^ w_b;
      c_op_not: w_res = ~w_a;
      c_op_shl: begin
        w_res = {w_a[2:0], 1'b0};
        w_c   = w_a[3];
      end
      c_op_shr: begin
        w_res = {1'b0, w_a[3:1]};
        w_c   = w_a[0];
      end
      c_op_asr: begin
        w_res = {w_a[3], w_a[3:1]};
        w_c   = w_a[0];
      end
      c_op_rol: begin
        w_res = {w_a[2:0], w_a[3]};
        w_c   = w_a[3];
      end
      c_op_inc: begin
        w_sum = {1'b0, w_a} + 5'd1;
        w_res = w_sum[3:0];
        w_c   = w_sum[4];
        w_v   = !w_a[3] && w_sum[3];
      end
      c_op_dec: begin
        w_sum = {1'b0, w_a} + 5'h0F;
        w_res = w_sum[3:0];
        w_c   = w_sum[4];
        w_v   = w_a[3] && !w_sum[3];
      end
      c_op_mul: begin
        w_res = w_prod[3:0];
        w_c   = |w_prod[7:4];
      end
      default: begin
        w_res = 4'd0;
      end
    endcase
  end

  // CMP keeps A on R but reports Z/N from the difference.
  assign w_flag_src = (w_op == c_op_cmp) ? w_sum[3:0] : w_res;
  assign w_z = (w_flag_src == 4'd0);
  assign w_n = w_flag_src[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= 8'h00;
    end else if (ena) begin
      r_out <= {w_v, w_n, w_z, w_c, w_res};
    end
  end

  assign uo_out  = r_out;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_sujith_alu4.sv
// ============================================================================
// Module      : tb_tt_um_sujith_alu4
// Description : Self-checking bench for the 4-bit ALU against an integer model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_sujith_alu4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q = 8'h00;
  logic cmp_en = 1'b0;

  tt_um_sujith_alu4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Integer reference: results and flags straight from the opcode definitions.
  function automatic logic [7:0] model(input logic [7:0] ui, input logic [7:0] uio);
    int a, b, cin, op, sa, sb, r, fl, d, s;
    bit c, v, arith;
    a = int'(ui[3:0]);
    b = int'(ui[7:4]);
    cin = int'(uio[4]);
    op = int'(uio[3:0]);
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    r = 0; c = 0; s = 0; arith = 0; fl = -1;
    case (op)
      0:  begin d = a + b;           r = d % 16; c = d > 15; s = sa + sb; arith = 1; end
      1:  begin d = a + b + cin;     r = d % 16; c = d > 15; s = sa + sb + cin; arith = 1; end
      2:  begin d = a - b;           r = (d + 16) % 16; c = d >= 0; s = sa - sb; arith = 1; end
      3:  begin d = a - b - 1 + cin; r = (d + 32) % 16; c = d >= 0; s = sa - sb - 1 + cin; arith = 1; end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = 15 - a;
      8:  begin r = (a * 2) % 16; c = a >= 8; end
      9:  begin r = a / 2; c = (a % 2) == 1; end
      10: begin r = a / 2 + ((a >= 8) ? 8 : 0); c = (a % 2) == 1; end
      11: begin r = (a * 2) % 16 + a / 8; c = a >= 8; end
      12: begin r = (a + 1) % 16; c = a == 15; s = sa + 1; arith = 1; end
      13: begin r = (a + 15) % 16; c = a != 0; s = sa - 1; arith = 1; end
      14: begin d = a * b; r = d % 16; c = d > 15; end
      default: begin d = a - b; r = a; fl = (d + 16) % 16; c = d >= 0; s = sa - sb; arith = 1; end
    endcase
    if (fl < 0) fl = r;
    v = arith && (s > 7 || s < -8);
    return {v, fl >= 8, fl == 0, c, 4'(r)};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= 8'h00;
    else if (ena) exp_q <= model(ui_in, uio_in);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("uo_out_vs_model", uo_out, exp_q);
      check("uio_out", uio_out, 8'h00);
      check("uio_oe", uio_oe, 8'h00);
    end
  end

  // Apply one operation just after a falling edge and check after the next rising edge.
  task automatic step(input string name, input logic [7:0] ui, input logic [7:0] uio,
                      input logic [7:0] want);
    ui_in = ui;
    uio_in = uio;
    @(posedge clk);
    @(negedge clk);
    #1;
    check(name, uo_out, want);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_async", uo_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    ena = 1'b1;
    ui_in = 8'h97;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_hold_edges", uo_out, 8'h00);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    step("add_7_9", 8'h97, 8'h00, 8'h30);
    step("add_7_1", 8'h17, 8'h00, 8'hC8);
    step("sub_3_5", 8'h53, 8'h02, 8'h4E);
    step("mul_7_3", 8'h37, 8'h0E, 8'h15);
    step("adc_f_0_c1", 8'h0F, 8'h11, 8'h30);
    step("adc_f_0_c0", 8'h0F, 8'h01, 8'h4F);
    step("cmp_5_5", 8'h55, 8'h0F, 8'h35);
    step("dec_8", 8'h08, 8'h0D, 8'h97);
    step("add_ignored_hi", 8'h17, 8'hE0, 8'hC8);

    // Hold while disabled, then asynchronous reset in the middle of a cycle.
    ena = 1'b0;
    ui_in = 8'h53;
    uio_in = 8'h0E;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("ena_low_hold", uo_out, 8'hC8);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_cycle", uo_out, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    ena = 1'b1;
    step("first_after_reset", 8'h97, 8'h00, 8'h30);

    for (int op = 0; op < 16; op++) begin
      for (int cin = 0; cin < 2; cin++) begin
        for (int ab = 0; ab < 256; ab++) begin
          ui_in = 8'(ab);
          uio_in = {3'($urandom), 1'(cin), 4'(op)};
          @(negedge clk);
          #1;
        end
      end
    end

    for (int i = 0; i < 3000; i++) begin
      ena = ($urandom_range(0, 3) != 0);
      ui_in = 8'($urandom);
      uio_in = 8'($urandom);
      if ($urandom_range(0, 63) == 0) rst_n = 1'b0;
      else if (!rst_n && $urandom_range(0, 1) == 1) rst_n = 1'b1;
      @(negedge clk);
      #1;
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
